// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI byte parser with running status and a monophonic last-note-priority voice.
// Sustain pedal handling (controller 64) is built only when MIDI_SUSTAIN_EN is defined.
module midi_note_decoder #(
  parameter int CHANNEL     = 0,
  parameter int BASE_PERIOD = 6115610
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  midi_byte,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        note_on,
  output logic        note_off,
  output logic [22:0] period,
  output logic [6:0]  cur_note,
  output logic [6:0]  velocity,
  output logic        sounding
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DATA1 = 3'd1;
  localparam logic [2:0] DATA2 = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] MUL   = 3'd4;
  localparam logic [2:0] EMIT  = 3'd5;
  localparam logic [3:0] CH    = 4'(CHANNEL);
  localparam logic [38:0] BASE = 39'(BASE_PERIOD);
  logic [2:0]  state;
  logic [1:0]  rs;
  logic        rs_ok;
  logic [6:0]  note, vel, rem;
  logic [3:0]  oct, cnt;
  logic [15:0] ratio;
  logic        accept, chan_ok, release_hit;
  assign byte_ready  = !(state == CALC || state == MUL || state == EMIT);
  assign accept      = byte_valid && byte_ready;
  assign release_hit = sounding && note == cur_note;
`ifdef MIDI_SUSTAIN_EN
  logic pedal, pending;
  assign chan_ok = midi_byte[3:0] == CH &&
                   (midi_byte[7:4] == 4'h8 || midi_byte[7:4] == 4'h9 || midi_byte[7:4] == 4'hB);
`else
  assign chan_ok = midi_byte[3:0] == CH && midi_byte[7:5] == 3'b100;
`endif
  // Q1.15 frequency ratio of each semitone below the octave root
  always_comb begin
    case (rem[3:0])
      4'd0:    ratio = 16'd32768;
      4'd1:    ratio = 16'd30929;
      4'd2:    ratio = 16'd29193;
      4'd3:    ratio = 16'd27554;
      4'd4:    ratio = 16'd26008;
      4'd5:    ratio = 16'd24548;
      4'd6:    ratio = 16'd23170;
      4'd7:    ratio = 16'd21870;
      4'd8:    ratio = 16'd20643;
      4'd9:    ratio = 16'd19484;
      4'd10:   ratio = 16'd18390;
      default: ratio = 16'd17358;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rs       <= 2'd0;
      rs_ok    <= 1'b0;
      note     <= 7'd0;
      vel      <= 7'd0;
      rem      <= 7'd0;
      oct      <= 4'd0;
      cnt      <= 4'd0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      period   <= 23'd0;
      cur_note <= 7'd0;
      velocity <= 7'd0;
      sounding <= 1'b0;
`ifdef MIDI_SUSTAIN_EN
      pedal    <= 1'b0;
      pending  <= 1'b0;
`endif
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      case (state)
        CALC: begin
          // fixed 11 passes: at most 10 subtractions are ever needed for a 7-bit note
          if (rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd10) state <= MUL;
        end
        MUL: begin
          period   <= 23'((BASE * {23'd0, ratio}) >> 15 >> oct);
          cur_note <= note;
          velocity <= vel;
          note_on  <= 1'b1;
          sounding <= 1'b1;
`ifdef MIDI_SUSTAIN_EN
          pending  <= 1'b0;
`endif
          state    <= EMIT;
        end
        EMIT: state <= DATA1;
        default: if (accept) begin
          if (midi_byte[7]) begin
            if (midi_byte[7:3] != 5'b11111) begin
              rs_ok <= chan_ok;
              rs    <= midi_byte[5:4];
              state <= chan_ok ? DATA1 : IDLE;
            end
          end else if (state == DATA2) begin
            vel <= midi_byte[6:0];
            state <= DATA1;
            if (rs == 2'b01 && midi_byte[6:0] != 7'd0) begin
              rem   <= note;
              oct   <= 4'd0;
              cnt   <= 4'd0;
              state <= CALC;
            end
`ifdef MIDI_SUSTAIN_EN
            else if (rs == 2'b11) begin
              if (note == 7'd64) begin
                pedal <= midi_byte[6];
                if (!midi_byte[6] && pending) begin
                  note_off <= 1'b1;
                  sounding <= 1'b0;
                  pending  <= 1'b0;
                end
              end
            end else if (release_hit) begin
              if (pedal) pending <= 1'b1;
              else begin
                note_off <= 1'b1;
                sounding <= 1'b0;
              end
            end
`else
            else if (release_hit) begin
              note_off <= 1'b1;
              sounding <= 1'b0;
            end
`endif
          end else if (state == DATA1 || rs_ok) begin
            note  <= midi_byte[6:0];
            state <= DATA2;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: scoreboard bench; expected pulses are queued as bytes are sent and matched on output.
module tb_midi_note_decoder;
  localparam longint BASE = 6115610;
  localparam int RT[12] = '{32768, 30929, 29193, 27554, 26008, 24548,
                            23170, 21870, 20643, 19484, 18390, 17358};
  typedef struct {
    logic on;
    int   due;
    int   per;
    int   nt;
    int   vl;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  midi_byte = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, note_on, note_off, sounding;
  logic [22:0] period;
  logic [6:0]  cur_note, velocity;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          lowrun = 0;
  int          acc;
  ev_t         q[$];
  ev_t         e;

  midi_note_decoder dut (
    .clk(clk), .rst(rst), .midi_byte(midi_byte), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .note_on(note_on), .note_off(note_off), .period(period),
    .cur_note(cur_note), .velocity(velocity), .sounding(sounding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask

  function automatic int exp_period(input int nt);
    longint r;
    r = (BASE * longint'(RT[nt % 12])) >> 15;
    return int'(r >> (nt / 12));
  endfunction

  task automatic send(input logic [7:0] b, output int at);
    int n = 0;
    @(negedge clk);
    midi_byte = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 0);
    at = cyc;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, acc);
    send(b, acc);
    send(c, acc);
  endtask

  task automatic push_on(input int at, input int nt, input int vl);
    q.push_back('{1'b1, at + 13, exp_period(nt), nt, vl});
  endtask

  task automatic push_off(input int at, input int nt);
    q.push_back('{1'b0, at + 1, 0, nt, 0});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) lowrun = 0;
    else begin
      if (note_on || note_off) begin
        chk("exclusive", 32'(note_on & note_off), 0);
        if (q.size() == 0) chk("unexpected_pulse", {30'd0, note_on, note_off}, 0);
        else begin
          e = q.pop_front();
          chk("kind", 32'(note_on), 32'(e.on));
          chk("latency", cyc, e.due);
          chk("cur_note", 32'(cur_note), e.nt);
          chk("sounding", 32'(sounding), 32'(e.on));
          if (e.on) begin
            chk("period", 32'(period), e.per);
            chk("velocity", 32'(velocity), e.vl);
            chk("period_nonzero", 32'(period != 0), 1);
          end
        end
      end
      if (!byte_ready) lowrun++;
      else if (lowrun != 0) begin
        chk("ready_low_cycles", lowrun, 13);
        lowrun = 0;
      end
    end
  end

  initial begin
    idle(3);
    chk("rst_outputs", {note_on, note_off, period, cur_note, velocity, sounding}, 0);
    chk("rst_ready", 32'(byte_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    // C4 from scratch, then A4 via running status sent while the decoder is still busy
    send3(8'h90, 8'h3C, 8'h64);
    push_on(acc, 60, 100);
    chk("model_c4", exp_period(60), 191112);
    send(8'h45, acc);
    send(8'h40, acc);
    push_on(acc, 69, 64);
    chk("model_a4", exp_period(69), 113636);
    idle(20);
    send3(8'h80, 8'h3C, 8'h00);
    idle(5);
    chk("stray_release_sounding", 32'(sounding), 1);
    send3(8'h90, 8'h45, 8'h00);
    push_off(acc, 69);
    idle(5);
    // realtime byte inside a message, then a message on another channel
    send(8'h90, acc);
    send(8'hF8, acc);
    send(8'h3C, acc);
    send(8'h50, acc);
    push_on(acc, 60, 80);
    send3(8'h91, 8'h3C, 8'h40);
    send(8'h40, acc);
    send(8'h40, acc);
    idle(20);
    chk("other_chan_note", 32'(cur_note), 60);
    chk("other_chan_sounding", 32'(sounding), 1);
    // extreme notes
    send3(8'h90, 8'h00, 8'h01);
    push_on(acc, 0, 1);
    send(8'h7F, acc);
    send(8'h7F, acc);
    push_on(acc, 127, 127);
    idle(20);
    // reset in the middle of CALC
    send3(8'h90, 8'h30, 8'h40);
    idle(4);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midcalc_outputs", {note_on, note_off, period, cur_note, velocity, sounding}, 0);
    chk("midcalc_ready", 32'(byte_ready), 1);
    send(8'h3C, acc);
    send(8'h64, acc);
    idle(20);
    chk("orphan_data_sounding", 32'(sounding), 0);
    chk("orphan_data_ready", 32'(byte_ready), 1);
`ifdef MIDI_SUSTAIN_EN
    send3(8'hB0, 8'h40, 8'h7F);
    send3(8'h90, 8'h3C, 8'h64);
    push_on(acc, 60, 100);
    send3(8'h80, 8'h3C, 8'h00);
    idle(5);
    chk("pedal_hold_sounding", 32'(sounding), 1);
    send3(8'hB0, 8'h40, 8'h00);
    push_off(acc, 60);
    idle(5);
`else
    send3(8'hB0, 8'h40, 8'h7F);
    send3(8'h90, 8'h3C, 8'h64);
    push_on(acc, 60, 100);
    send3(8'h80, 8'h3C, 8'h00);
    push_off(acc, 60);
    idle(5);
`endif
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
